// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM states,
// register word addresses, CTRL bit layout and mode codes.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_W   = 4;
    localparam int EN_BIT   = 0;
    localparam int MODE_LSB = 1;
    localparam int IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_dev.sv
// Programmable countdown timer: CTRL/PRESET/COUNT register file, decrementer
// and IDLE/LOAD/CNT/INT sequencer producing a maskable interrupt request.
module timer_dev
    import timer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             irq
);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [WIDTH-1:0]    preset_q, preset_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                exit_q, exit_d;

    logic ctrl_wr;
    logic preset_wr;
    logic en;
    logic reload;

    assign ctrl_wr   = we && (addr == ADDR_CTRL);
    assign preset_wr = we && (addr == ADDR_PRESET);
    assign en        = ctrl_q[EN_BIT];
    assign reload    = (ctrl_q[MODE_LSB +: 2] == MODE_RELOAD);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        exit_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: if (en) state_d = ST_LOAD;
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q <= WIDTH'(1)) begin
                    count_d = '0;
                    state_d = ST_INT;
                    if (!reload) ctrl_d[EN_BIT] = 1'b0;
                    // A CTRL write landing on the INT-entry edge still counts as the exit request.
                    exit_d  = ctrl_wr;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            ST_INT: begin
                if (reload)                 state_d = ST_LOAD;
                else if (ctrl_wr || exit_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // NOTE: the software write is applied last so it overrides the hardware En clear.
        if (ctrl_wr)   ctrl_d   = din[CTRL_W-1:0];
        if (preset_wr) preset_d = din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            exit_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            exit_q   <= exit_d;
        end
    end

    always_comb begin
        dout = '0;
        unique case (addr)
            ADDR_CTRL:   dout = {{(WIDTH-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: dout = preset_q;
            ADDR_COUNT:  dout = count_q;
            default:     dout = '0;
        endcase
    end

    assign irq = (state_q == ST_INT) && ctrl_q[IM_BIT];

endmodule
